// File: rtl/pet_io_pkg.sv
// Shared types for the PET I/O arbiter: FSM states, owner encoding, address width.
package pet_io_pkg;
    localparam int IO_AW = 11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;
endpackage

// File: rtl/pet_io_arbiter.sv
// Arbitrates the PET I/O register port (0xE800-0xEFFF) between the 6502 core
// and a host/debug requester. Each access holds io_* stable for SETUP_CYC
// cycles, fires a one-cycle io_strobe, then captures the registered read data.
module pet_io_arbiter
    import pet_io_pkg::*;
#(
    parameter int SETUP_CYC = 2   // 1..7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             cpu_sel,
    input  logic [IO_AW-1:0] cpu_addr,
    input  logic             cpu_we,
    input  logic [7:0]       cpu_wdata,
    output logic [7:0]       cpu_rdata,
    output logic             cpu_rdy,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [IO_AW-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_ack,
    output logic [IO_AW-1:0] io_addr,
    output logic             io_we,
    output logic [7:0]       io_wdata,
    output logic             io_strobe,
    input  logic [7:0]       io_rdata
);
    state_t     state, state_nxt;
    owner_t     owner, last_owner, grant_own;
    logic [2:0] cnt;
    logic       cpu_done;
    logic       cpu_pend;
    logic       host_pend;
    logic       grant;

    // A finished CPU access stays "done" until the core consumes it on ce.
    assign cpu_pend  = cpu_sel && !cpu_done;
    // The host holds req until it sees ack, so mask the ack cycle to avoid
    // re-granting a request that has already been served.
    assign host_pend = host_req && !host_ack;
    assign cpu_rdy   = reset || !cpu_pend;

    // Grant selection in IDLE; on contention the requester that did not go last wins.
    always_comb begin
        grant     = 1'b0;
        grant_own = OWN_CPU;
        if (state == IDLE) begin
            if (cpu_pend && host_pend) begin
                grant     = 1'b1;
                grant_own = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
            end else if (cpu_pend) begin
                grant     = 1'b1;
                grant_own = OWN_CPU;
            end else if (host_pend) begin
                grant     = 1'b1;
                grant_own = OWN_HOST;
            end
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SETUP;
            SETUP:   if (cnt == 3'd0) state_nxt = STROBE;
            STROBE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath: latch the granted request, count setup, strobe, capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_strobe  <= 1'b0;
            io_we      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
            cnt        <= '0;
            cpu_done   <= 1'b0;
            owner      <= OWN_CPU;
            last_owner <= OWN_CPU;
        end else begin
            // Registered so the strobe is high exactly while state == STROBE.
            io_strobe <= (state_nxt == STROBE);
            host_ack  <= (state == CAPTURE) && (owner == OWN_HOST);

            if (grant) begin
                owner <= grant_own;
                cnt   <= 3'(SETUP_CYC - 1);
                if (grant_own == OWN_CPU) begin
                    io_addr  <= cpu_addr;
                    io_we    <= cpu_we;
                    io_wdata <= cpu_wdata;
                end else begin
                    io_addr  <= host_addr;
                    io_we    <= host_we;
                    io_wdata <= host_wdata;
                end
            end else if (state == SETUP && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end

            // Consume a finished CPU access; a same-cycle CAPTURE set wins below.
            if (ce && cpu_rdy) cpu_done <= 1'b0;

            if (state == CAPTURE) begin
                last_owner <= owner;
                if (owner == OWN_CPU) begin
                    cpu_rdata <= io_rdata;
                    cpu_done  <= 1'b1;
                end else begin
                    host_rdata <= io_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_pet_io_arbiter.sv
// Directed bench for pet_io_arbiter: default build (SETUP_CYC=2) plus a
// SETUP_CYC=1 instance. Inputs driven 1ns after posedge, outputs sampled 2ns after.
module tb_pet_io_arbiter;
    logic        clk = 1'b0;
    logic        reset, ce;
    logic        cpu_sel, cpu_we, host_req, host_we;
    logic [10:0] cpu_addr, host_addr;
    logic [7:0]  cpu_wdata, host_wdata, io_rdata;
    logic [7:0]  cpu_rdata, host_rdata, io_wdata;
    logic        cpu_rdy, host_ack, io_we, io_strobe;
    logic [10:0] io_addr;

    logic        c1_sel;
    logic [10:0] c1_addr;
    logic [7:0]  c1_rdata, h1_rdata, io1_wdata, io1_rdata;
    logic        c1_rdy, h1_ack, io1_we, io1_strobe;
    logic [10:0] io1_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pet_io_arbiter dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata), .io_strobe(io_strobe),
        .io_rdata(io_rdata)
    );

    pet_io_arbiter #(.SETUP_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .ce(ce),
        .cpu_sel(c1_sel), .cpu_addr(c1_addr), .cpu_we(1'b0), .cpu_wdata(8'h00),
        .cpu_rdata(c1_rdata), .cpu_rdy(c1_rdy),
        .host_req(1'b0), .host_we(1'b0), .host_addr(11'h000), .host_wdata(8'h00),
        .host_rdata(h1_rdata), .host_ack(h1_ack),
        .io_addr(io1_addr), .io_we(io1_we), .io_wdata(io1_wdata), .io_strobe(io1_strobe),
        .io_rdata(io1_rdata)
    );

    // I/O block model: read data registered one clock after the address.
    function automatic logic [7:0] rmodel(input logic [10:0] a);
        case (a)
            11'h010: return 8'hA5;
            11'h020: return 8'h3C;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        io_rdata  <= rmodel(io_addr);
        io1_rdata <= rmodel(io1_addr);
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; cpu_sel = 1'b1; cpu_addr = 11'h7FF; cpu_we = 1'b1;
        cpu_wdata = 8'hFF; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        c1_sel = 1'b0; c1_addr = '0;
        @(posedge clk); #1; @(posedge clk); #1; #1;
        checks++; if (io_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b exp 0", io_strobe); end
        checks++; if (io_addr !== 11'h000) begin errors++; $display("FAIL reset_io_addr got %h exp 000", io_addr); end
        checks++; if (io_we !== 1'b0 || io_wdata !== 8'h00) begin errors++; $display("FAIL reset_io_we_wdata got %0b/%h exp 0/00", io_we, io_wdata); end
        checks++; if (cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h/%h exp 00/00", cpu_rdata, host_rdata); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack got %0b exp 0", host_ack); end
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_cpu_rdy got %0b exp 1", cpu_rdy); end
        reset = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        int ns = 0, sc = -1;
        logic r4 = 1'bx, r5 = 1'bx, r0 = 1'bx;
        cpu_sel = 1'b1; cpu_addr = 11'h010; cpu_we = 1'b0; ce = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            #1;
            if (io_strobe) begin ns++; sc = k; end
            if (k == 0) r0 = cpu_rdy;
            if (k == 4) r4 = cpu_rdy;
            if (k == 5) r5 = cpu_rdy;
            @(posedge clk); #1;
        end
        checks++; if (ns != 1 || sc != 3) begin errors++; $display("FAIL cpu_rd_strobe got count %0d cycle %0d exp 1 at 3", ns, sc); end
        checks++; if (r0 !== 1'b0 || r4 !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall got rdy %0b/%0b exp 0/0", r0, r4); end
        checks++; if (r5 !== 1'b1) begin errors++; $display("FAIL cpu_rd_release got rdy %0b exp 1", r5); end
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpu_rd_data got %h exp a5", cpu_rdata); end
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0; cpu_sel = 1'b0;
    endtask

    task automatic test_host_write();
        int ns = 0, sc = -1, na = 0, ac = -1;
        logic held = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h04E; host_wdata = 8'h7F;
        for (int k = 0; k <= 8; k++) begin
            #1;
            if (k >= 1 && k <= 4 && !(io_addr === 11'h04E && io_we === 1'b1 && io_wdata === 8'h7F)) held = 1'b0;
            if (io_strobe) begin ns++; sc = k; end
            if (host_ack) begin na++; ac = k; host_req = 1'b0; end
            @(posedge clk); #1;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL host_wr_hold got io_addr %h we %0b wdata %h exp 04e/1/7f", io_addr, io_we, io_wdata); end
        checks++; if (ns != 1 || sc != 3) begin errors++; $display("FAIL host_wr_strobe got count %0d cycle %0d exp 1 at 3", ns, sc); end
        checks++; if (na != 1 || ac != 5) begin errors++; $display("FAIL host_wr_ack got count %0d cycle %0d exp 1 at 5", na, ac); end
        checks++; if (host_rdata !== 8'h14) begin errors++; $display("FAIL host_wr_rdata got %h exp 14", host_rdata); end
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic test_contention();
        logic [10:0] sa [0:3];
        int ns = 0, low = 0, ac = -1;
        do_reset();
        cpu_sel = 1'b1; cpu_addr = 11'h012; cpu_we = 1'b0;
        host_req = 1'b1; host_addr = 11'h040; host_we = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            #1;
            if (io_strobe && ns < 4) begin sa[ns] = io_addr; ns++; end
            if (!cpu_rdy) low++;
            if (host_ack) begin ac = k; host_req = 1'b0; end
            @(posedge clk); #1;
        end
        checks++; if (ns != 2) begin errors++; $display("FAIL cont_strobe_count got %0d exp 2", ns); end
        checks++; if (ns < 2 || sa[0] !== 11'h040 || sa[1] !== 11'h012) begin errors++; $display("FAIL cont_order got %h,%h exp 040,012", sa[0], sa[1]); end
        checks++; if (low != 10) begin errors++; $display("FAIL cont_stall got %0d cycles exp 10", low); end
        checks++; if (ac != 5) begin errors++; $display("FAIL cont_host_ack got cycle %0d exp 5", ac); end
        checks++; if (cpu_rdata !== 8'h48 || host_rdata !== 8'h1A) begin errors++; $display("FAIL cont_rdata got %h/%h exp 48/1a", cpu_rdata, host_rdata); end
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0; cpu_sel = 1'b0;
    endtask

    task automatic test_fairness();
        logic [10:0] fa [0:9];
        logic [10:0] ex;
        int ns = 0, ci = 0, hi = 0, dbl = 0;
        logic prev = 1'b0, r, a;
        do_reset();
        ce = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h200;
        for (int k = 0; k < 100 && ns < 10; k++) begin
            #1;
            if (io_strobe) begin
                if (prev) dbl++;
                fa[ns] = io_addr; ns++;
            end
            prev = io_strobe; r = cpu_rdy; a = host_ack;
            @(posedge clk); #1;
            if (r) begin ci++; cpu_addr = 11'(32'h100 + ci); end
            if (a) begin hi++; host_addr = 11'(32'h200 + hi); end
        end
        checks++; if (ns != 10) begin errors++; $display("FAIL fair_count got %0d exp 10", ns); end
        for (int i = 0; i < 10; i++) begin
            ex = (i % 2 == 0) ? 11'(32'h200 + i / 2) : 11'(32'h100 + i / 2);
            checks++; if (i < ns && fa[i] !== ex) begin errors++; $display("FAIL fair_grant_%0d got %h exp %h", i, fa[i], ex); end
        end
        checks++; if (dbl != 0) begin errors++; $display("FAIL fair_double_strobe got %0d exp 0", dbl); end
        cpu_sel = 1'b0; host_req = 1'b0;
        for (int k = 0; k < 12; k++) begin @(posedge clk); #1; end
        ce = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic hit = 1'b0;
        int bad = 0;
        do_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h033;
        for (int k = 0; k < 10 && !hit; k++) begin
            #1;
            if (io_strobe) begin hit = 1'b1; reset = 1'b1; end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_no_strobe got none exp strobe within 10"); end
        #1;
        checks++; if (io_strobe !== 1'b0 || host_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got strobe %0b ack %0b exp 0/0", io_strobe, host_ack); end
        checks++; if (io_addr !== 11'h000 || host_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_regs got %h/%h exp 000/00", io_addr, host_rdata); end
        reset = 1'b0; host_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1; #1;
            if (host_ack || io_strobe) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_after got %0d active cycles exp 0", bad); end
        #1;
    endtask

    task automatic test_setup1();
        int ns = 0, sc = -1;
        logic r3 = 1'bx, r4 = 1'bx;
        c1_sel = 1'b1; c1_addr = 11'h020;
        for (int k = 0; k <= 6; k++) begin
            #1;
            if (io1_strobe) begin ns++; sc = k; end
            if (k == 3) r3 = c1_rdy;
            if (k == 4) r4 = c1_rdy;
            @(posedge clk); #1;
        end
        checks++; if (ns != 1 || sc != 2) begin errors++; $display("FAIL s1_strobe got count %0d cycle %0d exp 1 at 2", ns, sc); end
        checks++; if (r3 !== 1'b0 || r4 !== 1'b1) begin errors++; $display("FAIL s1_rdy got %0b/%0b exp 0/1", r3, r4); end
        checks++; if (c1_rdata !== 8'h3C) begin errors++; $display("FAIL s1_rdata got %h exp 3c", c1_rdata); end
        c1_sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_host_write();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_setup1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pet_io_arbiter.md
Name: pet_io_arbiter

Overview:
Sequences every access to the PET I/O block (PIA1/PIA2/VIA, region 0xE800-0xEFFF). The block shares that single register port between the 6502 core and a host/debug requester, such as an OSD loader or a keystroke injector. It generates the one-shot I/O strobe after a programmable setup delay. It captures the registered read data and stalls the CPU through RDY until its access has completed.

Parameters:
SETUP_CYC, 2, clk cycles that io_addr/io_we/io_wdata are held stable before io_strobe; legal range 1..7.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  CPU clock-enable; a CPU bus cycle completes on ce && cpu_rdy
cpu_sel  in  1  CPU address decodes to the I/O region
cpu_addr  in  11  CPU address[10:0]
cpu_we  in  1  CPU write
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  captured read data for the CPU
cpu_rdy  out  1  combinational; 0 stalls the CPU
host_req  in  1  level request; held until host_ack
host_we  in  1  host write
host_addr  in  11  host address
host_wdata  in  8  host write data
host_rdata  out  8  captured host read data
host_ack  out  1  one-cycle completion pulse
io_addr  out  11  to I/O block
io_we  out  1  to I/O block
io_wdata  out  8  to I/O block
io_strobe  out  1  one-cycle access strobe to I/O block
io_rdata  in  8  from I/O block, registered one clk after io_addr

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values:
  - io_strobe=0, io_we=0, io_addr=0, io_wdata=0
  - cpu_rdata=0, host_rdata=0, host_ack=0
  - state=IDLE, cnt=0, cpu_done=0, last_owner=CPU
- cpu_rdy = !(cpu_sel && !cpu_done). cpu_rdy is 1 during reset.
- cpu_done:
  - Set in the CAPTURE cycle of a CPU-owned access.
  - Cleared on ce && cpu_rdy, which consumes the finished access.
- The CPU core holds its address, we and wdata stable while cpu_rdy=0.
- cpu_pend = cpu_sel && !cpu_done. The arbiter samples this pend level; the request is not edge-based.
- States:
  - IDLE:
    - Choose an owner. If both cpu_pend and host_req are set, grant the requester that is not last_owner (alternating fairness). Otherwise grant whichever is requesting.
    - On grant: latch the owner's addr/we/wdata into the io_* registers, load cnt=SETUP_CYC-1, and go to SETUP.
  - SETUP: io_strobe=0. When cnt==0, go to STROBE; otherwise decrement cnt.
  - STROBE: io_strobe=1 for exactly one cycle; go to CAPTURE.
  - CAPTURE:
    - Latch io_rdata into the owner's rdata register. The latch happens on writes too; software ignores the value.
    - Set last_owner. If the owner is CPU, set cpu_done. If the owner is HOST, assert host_ack in the next cycle.
    - Return to IDLE.
- io_* outputs hold their values from grant through CAPTURE and keep the last values while IDLE.
- Access latency: grant to CAPTURE = SETUP_CYC+2 cycles. With the default this is 4 cycles; with SETUP_CYC=1 it is 3 cycles.
- cpu_rdata holds its value until the next CPU-owned CAPTURE. host_rdata holds its value until the next host-owned CAPTURE.
- Back-to-back accesses: the earliest next grant is the cycle after CAPTURE (IDLE). There is no dead cycle beyond IDLE.
- cpu_sel drop: if cpu_sel drops while a CPU access is in flight, the access still completes. cpu_done is then set but not consumed. cpu_done clears on the next ce && cpu_rdy. Since cpu_sel=0 makes cpu_rdy=1, it clears on the next ce.
- host_req drop: if host_req drops before grant, no access is made. After grant the access completes and host_ack still pulses.
- Reset mid-access: the access is aborted. No host_ack, no strobe, and all registers return to their reset values.
- io_strobe is never asserted for two consecutive cycles and never asserted outside STROBE.

Decomposition:
- Shared package pet_io_pkg:
  - State enum: IDLE, SETUP, STROBE, CAPTURE
  - Owner encoding: OWN_CPU=0, OWN_HOST=1
  - IO_AW=11
- No sub-module. The arbiter and sequencer are a single FSM with a 3-bit counter.

Test Plan:
- CPU read only: cpu_sel=1, cpu_addr=0x010, io_rdata model returns 0xA5.
  - Required: io_strobe pulses exactly once, 3 cycles after grant.
  - Required: cpu_rdy goes low, then returns to 1 in the cycle after CAPTURE.
  - Required: cpu_rdata=0xA5.
- Host write: host_req with host_addr=0x04E, host_wdata=0x7F, host_we=1, CPU idle.
  - Required: io_addr=0x04E, io_we=1, io_wdata=0x7F held from grant through CAPTURE.
  - Required: one host_ack pulse, 5 cycles after the grant edge.
- Contention: CPU (0x012) and host (0x040) requests in the same cycle after reset, last_owner=CPU.
  - Required: host is granted first and the CPU is granted next.
  - Required: cpu_rdy is low for the full 8+ cycles.
  - Required: two strobes, addresses in order 0x040 then 0x012.
- Fairness: host_req held high continuously and CPU accessing every ce.
  - Required: grants strictly alternate CPU/HOST over 10 accesses.
  - Required: no requester waits more than one access.
- Reset mid-access: assert reset in the STROBE cycle of a host access.
  - Required: next cycle io_strobe=0 and host_ack=0.
  - Required: state=IDLE, and host_ack never pulses for the aborted access.
- SETUP_CYC=1 build: CPU read of 0x020 with io_rdata=0x3C.
  - Required: strobe 2 cycles after grant, CAPTURE at 3, cpu_rdata=0x3C.
